// File: rtl/lsu.sv
// Load/store unit: single-outstanding memory handshake with store lane
// replication/byte enables and load alignment with sign/zero extension.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  sb_rd_waddr,
    output logic [31:0] sb_rd_wdata,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                    state, state_n;
    logic                      op_we, op_we_n;
    logic [2:0]                op_f3, op_f3_n;
    logic [1:0]                op_off, op_off_n;
    logic [REG_ADDR_WIDTH-1:0] op_rd, op_rd_n;

    logic                      mem_req_n, mem_we_n;
    logic [DATA_WIDTH-1:0]     mem_addr_n, mem_wdata_n;
    logic [BE_WIDTH-1:0]       mem_be_n;
    logic [REG_ADDR_WIDTH-1:0] sb_waddr_n;
    logic [DATA_WIDTH-1:0]     sb_wdata_n;
    logic                      done_n, err_n;

    logic                      misaligned, illegal;
    logic [DATA_WIDTH-1:0]     st_wdata;
    logic [BE_WIDTH-1:0]       st_be;
    logic [DATA_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]     load_data;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = !req_ready;

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; illegal width codes rejected per direction.
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign illegal    = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                               : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));

    // Store data lane replication and byte enables; loads request the full word.
    always_comb begin
        st_wdata = '0;
        st_be    = 4'b1111;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{req_wdata[7:0]}};
                    st_be    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    st_wdata = {2{req_wdata[15:0]}};
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = req_wdata;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Align the returned word to the addressed byte and extend to full width.
    always_comb begin
        shifted = mem_rdata >> {op_off, 3'b000};
        case (op_f3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        op_we_n     = op_we;
        op_f3_n     = op_f3;
        op_off_n    = op_off;
        op_rd_n     = op_rd;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_be_n    = mem_be;
        sb_waddr_n  = '0;
        sb_wdata_n  = '0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_we_n  = req_we;
                    op_f3_n  = req_funct3;
                    op_off_n = req_addr[1:0];
                    op_rd_n  = req_rd;
                    if (misaligned || illegal) begin
                        err_n = 1'b1;
                    end else begin
                        state_n     = REQ;
                        mem_req_n   = 1'b1;
                        mem_we_n    = req_we;
                        mem_addr_n  = {req_addr[31:2], 2'b00};
                        mem_wdata_n = st_wdata;
                        mem_be_n    = st_be;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_n = 1'b0;
                    if (op_we) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (op_rd != '0) begin
                        sb_waddr_n = op_rd;
                        sb_wdata_n = load_data;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_we       <= 1'b0;
            op_f3       <= '0;
            op_off      <= '0;
            op_rd       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            sb_rd_waddr <= '0;
            sb_rd_wdata <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            op_we       <= op_we_n;
            op_f3       <= op_f3_n;
            op_off      <= op_off_n;
            op_rd       <= op_rd_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            mem_be      <= mem_be_n;
            sb_rd_waddr <= sb_waddr_n;
            sb_rd_wdata <= sb_wdata_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: cycle expectations from a transaction-level model plus literal pins.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  sb_rd_waddr;
    logic [31:0] sb_rd_wdata;
    logic        done, err, busy;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    logic        e_ready, e_req, e_we, e_done, e_err;
    logic [31:0] e_addr, e_wdata, e_sb_data;
    logic [3:0]  e_be;
    logic [4:0]  e_sb_addr;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sb_rd_waddr(sb_rd_waddr), .sb_rd_wdata(sb_rd_wdata),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Access size in bytes for a width code.
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        int sz;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = size_of(f3);
        return !legal || ((int'(addr[1:0]) % sz) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int base, sz;
        sz = size_of(f3);
        base = int'(addr[1:0]);
        be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= base && i < base + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v, mask;
        int sz;
        sz = size_of(f3);
        v = rdata >> (8 * int'(addr[1:0]));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle comparison against the expected outputs.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(!e_ready));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("sb_rd_waddr", 32'(sb_rd_waddr), 32'(e_sb_addr));
        chk("sb_rd_wdata", sb_rd_wdata, e_sb_data);
        if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_be", 32'(mem_be), 32'(e_be));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        e_done    = 1'b0;
        e_err     = 1'b0;
        e_sb_addr = '0;
        e_sb_data = '0;
    endtask

    task automatic set_idle();
        e_ready = 1'b1;
        e_req   = 1'b0;
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rvd,
                          input logic [31:0] rdata, input bit noise,
                          output logic [31:0] got_wd, output logic [3:0] got_be,
                          output logic [31:0] got_rd);
        logic bad;
        bad = model_err(we, f3, addr);
        got_wd = '0;
        got_be = '0;
        got_rd = '0;
        step();
        set_idle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();
        if (bad) begin
            req_valid = 1'b0;
            e_err = 1'b1;
            @(negedge clk);
            return;
        end
        req_valid = noise;
        req_addr  = addr ^ 32'h40;
        req_wdata = ~wd;
        e_ready = 1'b0;
        e_req   = 1'b1;
        e_we    = we;
        e_addr  = {addr[31:2], 2'b00};
        e_wdata = we ? model_wdata(f3, wd) : 32'd0;
        e_be    = we ? model_be(f3, addr) : 4'b1111;
        mem_gnt = (gd == 0);
        mem_rvalid = noise;
        mem_rdata  = 32'hBAD0_0000;
        @(negedge clk);
        got_wd = mem_wdata;
        got_be = mem_be;
        for (int i = 1; i <= gd; i++) begin
            step();
            mem_gnt = (i == gd);
        end
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        e_req = 1'b0;
        if (we) begin
            req_valid = 1'b0;
            e_done  = 1'b1;
            e_ready = 1'b1;
            @(negedge clk);
            return;
        end
        mem_gnt = noise;
        mem_rvalid = (rvd == 0);
        mem_rdata = (rvd == 0) ? rdata : 32'h5555_AAAA;
        for (int i = 1; i <= rvd; i++) begin
            step();
            mem_gnt = noise;
            mem_rvalid = (i == rvd);
            mem_rdata = (i == rvd) ? rdata : 32'h5555_AAAA;
        end
        step();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        req_valid  = 1'b0;
        e_ready    = 1'b1;
        e_done     = 1'b1;
        e_sb_addr  = rd;
        e_sb_data  = (rd != 5'd0) ? model_load(f3, addr, rdata) : 32'd0;
        @(negedge clk);
        got_rd = sb_rd_wdata;
    endtask

    initial begin
        logic [31:0] gw, gr;
        logic [3:0]  gb;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        e_ready = 1'b0; e_req = 1'b0; e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_addr = '0; e_wdata = '0; e_be = '0; e_sb_addr = '0; e_sb_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        step();
        rst = 1'b0;
        set_idle();

        // LW zero-wait
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0, gw, gb, gr);
        chk("lw_data", gr, 32'hDEADBEEF);
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80FF_0000, 1'b0, gw, gb, gr);
        chk("lb_data", gr, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 1, 1, 32'h80FF_0000, 1'b0, gw, gb, gr);
        chk("lbu_data", gr, 32'h00000080);
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 2, 32'h80FF_0000, 1'b0, gw, gb, gr);
        chk("lh_data", gr, 32'hFFFF80FF);
        // SB with gnt held low three cycles
        run_op(1'b1, 3'b000, 32'h201, 32'h12345678, 5'd0, 3, 0, 32'h0, 1'b0, gw, gb, gr);
        chk("sb_wdata", gw, 32'h78787878);
        chk("sb_be", 32'(gb), 32'(4'b0010));
        run_op(1'b1, 3'b001, 32'h302, 32'hAABBCCDD, 5'd0, 1, 0, 32'h0, 1'b0, gw, gb, gr);
        chk("sh_wdata", gw, 32'hCCDDCCDD);
        chk("sh_be", 32'(gb), 32'(4'b1100));
        run_op(1'b1, 3'b010, 32'h400, 32'h01020304, 5'd0, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        chk("sw_be", 32'(gb), 32'(4'b1111));
        // Error cases
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 5'd5, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd5, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        run_op(1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        run_op(1'b1, 3'b001, 32'h301, 32'h0, 5'd0, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        run_op(1'b0, 3'b101, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0, gw, gb, gr);
        // Load to x0
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd0, 0, 0, 32'hFFFFFFFF, 1'b0, gw, gb, gr);
        chk("x0_data", gr, 32'd0);
        // LHU with ignored gnt/rvalid/req_valid noise
        run_op(1'b0, 3'b101, 32'h106, 32'h0, 5'd12, 2, 2, 32'h1234ABCD, 1'b1, gw, gb, gr);
        chk("lhu_data", gr, 32'h00001234);

        // Reset while waiting for read data, then a late rvalid
        step();
        set_idle();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd5;
        step();
        req_valid = 1'b0;
        e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h100; e_wdata = 32'd0; e_be = 4'b1111;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        e_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_idle();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_rvalid = 1'b0;
        step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
